xbar_ctrl_port_pipelined: RTL and testbench
===========================================

# xbar_ctrl_port_pipelined

Parametrised crossbar controller-side port with pipelined grant/response handshake. Decodes the upper word-address bits of a controller request onto one of NUM_PORTS peripheral ports, tracks the granted transaction for one cycle, and returns read data, a response-valid strobe and a decode-error flag. It sits between one core-side bus master and the crossbar arbiters, with one instance per controller. Because the response cycle is pipelined, back-to-back transactions run at full rate.

## Interface
- WORD_ADDR_WIDTH, 16, controller word-address width; must be >= SEL_WIDTH+1
- NUM_PORTS, 4, number of peripheral ports; 2..16, need not be a power of two
- SEL_WIDTH, $clog2(NUM_PORTS), derived (localparam); number of top address bits used for decode

- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- c_req_i  in  1  controller request
- c_addr_i  in  WORD_ADDR_WIDTH  word address
- c_wen_i  in  1  1 = write
- c_wdata_i  in  32  write data (passed through by crossbar, unused here)
- c_be_i  in  4  byte enables (passed through, unused here)
- c_gnt_o  out  1  request accepted this cycle
- c_rvalid_o  out  1  response valid (reads and writes)
- c_rdata_o  out  32  read data, valid with c_rvalid_o
- c_err_o  out  1  decode error, valid with c_rvalid_o
- port_requested_o  out  NUM_PORTS  one-hot requested peripheral
- p_gnt_and_selected_i  in  NUM_PORTS  peripheral granted this controller
- p_rdata_i  in  32*NUM_PORTS  peripheral read data, port k at [32k+31:32k], valid the cycle after that port's grant

## Operation
- Decode: sel = c_addr_i[WORD_ADDR_WIDTH-1 -: SEL_WIDTH]. sel < NUM_PORTS is a legal decode; otherwise it is a decode error.
- port_requested_o = onehot(sel) when c_req_i && legal && rst_ni; otherwise 0.
- c_gnt_o = |(p_gnt_and_selected_i & port_requested_o) for legal requests; = c_req_i for illegal requests (local grant, no peripheral touched). Forced 0 while rst_ni low.
- Grants on ports not requested are ignored (crossbar bug guard); they do not assert c_gnt_o.
- Response register, updated every cycle:
  - rsp_valid_q <= c_gnt_o
  - rsp_sel_q <= sel
  - rsp_wen_q <= c_wen_i
  - rsp_err_q <= illegal
  - These capture the current cycle's request fields when granted.
- Outputs from the registers:
  - c_rvalid_o = rsp_valid_q
  - c_err_o = rsp_valid_q & rsp_err_q
  - c_rdata_o = p_rdata_i[rsp_sel_q] when rsp_valid_q && !rsp_wen_q && !rsp_err_q; otherwise 0.
- States: IDLE (rsp_valid_q=0) and RESP (rsp_valid_q=1).
  - IDLE -> RESP on c_gnt_o.
  - RESP -> RESP on c_gnt_o (back-to-back).
  - RESP -> IDLE otherwise.
- Controller protocol: c_req_i and its address/data are held stable until c_gnt_o. Dropping c_req_i before grant is tolerated; nothing is issued and no response follows.

## Timing
- Reset (rst_ni low at the edge) clears rsp_valid_q, rsp_err_q, rsp_wen_q and rsp_sel_q to 0. From the next cycle: c_rvalid_o=0, c_err_o=0, c_rdata_o=0. c_gnt_o and port_requested_o are 0 combinationally for as long as rst_ni is low.
- Grant latency is combinational from p_gnt_and_selected_i (0 cycles). Illegal requests are granted in the same cycle as c_req_i.
- Response latency is exactly 1 cycle after c_gnt_o.
- Throughput is one transaction per cycle. A new grant in the same cycle as a response is the normal pipelined case.
- Reset asserted while a response is pending: the response is dropped, with no rvalid in the cycle after the reset edge. A request granted in the same cycle as reset is discarded.
- Address changing between grant and response does not affect c_rdata_o; rsp_sel_q is used.
- NUM_PORTS a power of two: illegal decode is unreachable and c_err_o stays 0.

## Test plan
- NUM_PORTS=4, WORD_ADDR_WIDTH=16, read of addr 0x8004 -> port_requested_o=4'b0100. Grant on bit 2 -> c_gnt_o=1 in the same cycle. Next cycle c_rvalid_o=1, c_rdata_o = port-2 data 0xA5A5_0002, c_err_o=0.
- Back-to-back reads to ports 0, 3, 1, each granted immediately, with port data 0x1000_000k -> c_rvalid_o high for 3 consecutive cycles, with rdata 0x1000_0000, 0x1000_0003, 0x1000_0001 in order.
- Write to port 1, granted -> next cycle c_rvalid_o=1, c_rdata_o=0, c_err_o=0. Request held 3 cycles without grant -> c_gnt_o=0 and no rvalid until the grant cycle.
- NUM_PORTS=3, request to addr 0xC000 (sel=3) -> port_requested_o=0, c_gnt_o=1 same cycle. Next cycle c_rvalid_o=1, c_err_o=1, c_rdata_o=0.
- Spurious grant: p_gnt_and_selected_i=4'b0010 while requesting port 0 -> c_gnt_o=0, no response.
- Grant in cycle N, rst_ni low in cycle N+1 -> c_rvalid_o=0 in cycle N+1 onward, all outputs 0. After release, the first new grant responds normally.

Source files
------------

// File: rtl/xbar_ctrl_port_pipelined_if.sv
// Bundles the controller request/response and crossbar grant/data signals.
// Latency: wires only; it adds no cycles.
// Backpressure: the controller holds its request until c_gnt_o is asserted.
interface xbar_ctrl_port_pipelined_if #(
   parameter int WORD_ADDR_WIDTH = 16,
   parameter int NUM_PORTS       = 4
);
   logic                       c_req_i;
   logic [WORD_ADDR_WIDTH-1:0] c_addr_i;
   logic                       c_wen_i;
   logic [31:0]                c_wdata_i;
   logic [3:0]                 c_be_i;
   logic                       c_gnt_o;
   logic                       c_rvalid_o;
   logic [31:0]                c_rdata_o;
   logic                       c_err_o;
   logic [NUM_PORTS-1:0]       port_requested_o;
   logic [NUM_PORTS-1:0]       p_gnt_and_selected_i;
   logic [32*NUM_PORTS-1:0]    p_rdata_i;

   // Controller plus crossbar side, which drives the port block
   modport master (
      output c_req_i, c_addr_i, c_wen_i, c_wdata_i, c_be_i,
      output p_gnt_and_selected_i, p_rdata_i,
      input  c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o, port_requested_o
   );

   // The port block itself
   modport slave (
      input  c_req_i, c_addr_i, c_wen_i, c_wdata_i, c_be_i,
      input  p_gnt_and_selected_i, p_rdata_i,
      output c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o, port_requested_o
   );
endinterface

// File: rtl/xbar_ctrl_port_pipelined.sv
// Controller-side crossbar port: decodes the top address bits to a peripheral and returns the response.
// Latency: the grant is combinational and the response follows 1 cycle after the grant, at 1 transaction per cycle.
// Backpressure: the request is stalled until the selected peripheral grants it; an illegal decode is granted locally.
module xbar_ctrl_port_pipelined #(
   parameter int WORD_ADDR_WIDTH = 16,
   parameter int NUM_PORTS       = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   xbar_ctrl_port_pipelined_if.slave bus
);
   localparam int SEL_WIDTH = $clog2(NUM_PORTS);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SEL_WIDTH-1:0] r_sel;
   logic                 r_wen;
   logic                 r_err;

   logic [SEL_WIDTH-1:0] w_sel;
   logic                 w_legal;
   logic                 w_gnt;
   logic [NUM_PORTS-1:0] w_port_req;
   logic [31:0]          w_rdata_mux;
   logic                 w_rsp_vld;
   logic                 w_unused;

   assign w_sel   = bus.c_addr_i[WORD_ADDR_WIDTH-1 -: SEL_WIDTH];
   assign w_legal = (32'(w_sel) < NUM_PORTS);

   // Write data, byte enables and low address bits only pass through the crossbar
   assign w_unused = ^{bus.c_wdata_i, bus.c_be_i,
                       bus.c_addr_i[WORD_ADDR_WIDTH-SEL_WIDTH-1:0]};

   // Decode: one-hot port request; grants on ports that were not requested are masked off
   always_comb begin
      w_port_req = '0;
      w_gnt      = 1'b0;
      if (rst_ni && bus.c_req_i) begin
         if (w_legal) begin
            w_port_req = NUM_PORTS'(1) << w_sel;
            w_gnt      = |(bus.p_gnt_and_selected_i & w_port_req);
         end else begin
            w_gnt = 1'b1;
         end
      end
   end

   // Response-pending state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // A new grant keeps or enters RESP; otherwise the pipeline drains to IDLE
   always_comb begin
      w_state_nxt = IDLE;
      case (r_state)
         IDLE:    if (w_gnt) w_state_nxt = RESP;
         RESP:    if (w_gnt) w_state_nxt = RESP;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture the request fields every cycle; they are only used when a grant occurred
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sel <= '0;
         r_wen <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_sel <= w_sel;
         r_wen <= bus.c_wen_i;
         r_err <= !w_legal;
      end
   end

   // Read-data mux indexed by the registered select, so a later address change has no effect
   always_comb begin
      w_rdata_mux = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (r_sel == SEL_WIDTH'(k)) w_rdata_mux = bus.p_rdata_i[32*k +: 32];
      end
   end

   // Silence the response while reset is held so an in-flight response is dropped
   assign w_rsp_vld = rst_ni && (r_state == RESP);

   assign bus.port_requested_o = w_port_req;
   assign bus.c_gnt_o          = w_gnt;
   assign bus.c_rvalid_o       = w_rsp_vld;
   assign bus.c_err_o          = w_rsp_vld & r_err;
   assign bus.c_rdata_o        = (w_rsp_vld && !r_wen && !r_err) ? w_rdata_mux : 32'h0;
endmodule

// File: tb/tb_xbar_ctrl_port_pipelined.sv
// Bench for the crossbar controller port: a vector table on a 4-port instance, plus hand sequences and random traffic on a 3-port instance.
// Latency: it checks the combinational grant and the response 1 cycle after the grant.
// Backpressure: requests are held without a grant, and spurious grants are applied.
module tb_xbar_ctrl_port_pipelined;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 clk = ~clk;

   xbar_ctrl_port_pipelined_if #(.WORD_ADDR_WIDTH(16), .NUM_PORTS(4)) bus4 ();
   xbar_ctrl_port_pipelined_if #(.WORD_ADDR_WIDTH(16), .NUM_PORTS(3)) bus3 ();

   xbar_ctrl_port_pipelined #(.WORD_ADDR_WIDTH(16), .NUM_PORTS(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus4));
   xbar_ctrl_port_pipelined #(.WORD_ADDR_WIDTH(16), .NUM_PORTS(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus3));

   typedef struct {
      logic        rst_n;
      logic        req;
      logic [15:0] addr;
      logic        wen;
      logic [3:0]  pgnt;
      logic [31:0] base;
      logic        e_gnt;
      logic [3:0]  e_preq;
      logic        e_rv;
      logic        e_err;
      logic [31:0] e_rd;
   } vec_t;

   typedef struct {
      logic is_rd;
      int   port;
      logic err;
   } rsp_t;

   vec_t        tv[20];
   rsp_t        pend[$];
   rsp_t        cur;
   logic [31:0] prd[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive3(input logic req, input logic [15:0] addr, input logic wen,
                         input logic [2:0] pgnt);
      bus3.c_req_i              = req;
      bus3.c_addr_i             = addr;
      bus3.c_wen_i              = wen;
      bus3.p_gnt_and_selected_i = pgnt;
      bus3.p_rdata_i            = {prd[2], prd[1], prd[0]};
   endtask

   task automatic chk3(input string nm, input logic e_gnt, input logic [2:0] e_preq,
                       input logic e_rv, input logic e_err, input logic [31:0] e_rd);
      chk({nm, " gnt"},   32'(bus3.c_gnt_o),          32'(e_gnt));
      chk({nm, " preq"},  32'(bus3.port_requested_o), 32'(e_preq));
      chk({nm, " rv"},    32'(bus3.c_rvalid_o),       32'(e_rv));
      chk({nm, " err"},   32'(bus3.c_err_o),          32'(e_err));
      chk({nm, " rdata"}, bus3.c_rdata_o,             e_rd);
   endtask

   initial begin
      //        rst  req addr      wen pgnt     base           gnt preq     rv   err  rdata
      tv[0]  = '{1'b0,1'b1,16'h8004,1'b0,4'b0100,32'hA5A5_0000,1'b0,4'b0000,1'b0,1'b0,32'h0};
      tv[1]  = '{1'b1,1'b1,16'h8004,1'b0,4'b0100,32'hA5A5_0000,1'b1,4'b0100,1'b0,1'b0,32'h0};
      tv[2]  = '{1'b1,1'b0,16'h8004,1'b0,4'b0000,32'hA5A5_0000,1'b0,4'b0000,1'b1,1'b0,32'hA5A5_0002};
      tv[3]  = '{1'b1,1'b1,16'h0000,1'b0,4'b0001,32'h1000_0000,1'b1,4'b0001,1'b0,1'b0,32'h0};
      tv[4]  = '{1'b1,1'b1,16'hC000,1'b0,4'b1000,32'h1000_0000,1'b1,4'b1000,1'b1,1'b0,32'h1000_0000};
      tv[5]  = '{1'b1,1'b1,16'h4000,1'b0,4'b0010,32'h1000_0000,1'b1,4'b0010,1'b1,1'b0,32'h1000_0003};
      tv[6]  = '{1'b1,1'b0,16'h0000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0000,1'b1,1'b0,32'h1000_0001};
      tv[7]  = '{1'b1,1'b1,16'h4000,1'b1,4'b0010,32'h1000_0000,1'b1,4'b0010,1'b0,1'b0,32'h0};
      tv[8]  = '{1'b1,1'b1,16'h4000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0010,1'b1,1'b0,32'h0};
      tv[9]  = '{1'b1,1'b1,16'h4000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0010,1'b0,1'b0,32'h0};
      tv[10] = '{1'b1,1'b1,16'h4000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0010,1'b0,1'b0,32'h0};
      tv[11] = '{1'b1,1'b1,16'h4000,1'b0,4'b0010,32'h1000_0000,1'b1,4'b0010,1'b0,1'b0,32'h0};
      tv[12] = '{1'b1,1'b0,16'h4000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0000,1'b1,1'b0,32'h1000_0001};
      tv[13] = '{1'b1,1'b1,16'h0000,1'b0,4'b0010,32'h1000_0000,1'b0,4'b0001,1'b0,1'b0,32'h0};
      tv[14] = '{1'b1,1'b0,16'h0000,1'b0,4'b0010,32'h1000_0000,1'b0,4'b0000,1'b0,1'b0,32'h0};
      tv[15] = '{1'b1,1'b1,16'h8004,1'b0,4'b0100,32'h1000_0000,1'b1,4'b0100,1'b0,1'b0,32'h0};
      tv[16] = '{1'b0,1'b1,16'h0000,1'b0,4'b0001,32'h1000_0000,1'b0,4'b0000,1'b0,1'b0,32'h0};
      tv[17] = '{1'b0,1'b0,16'h0000,1'b0,4'b0000,32'h1000_0000,1'b0,4'b0000,1'b0,1'b0,32'h0};
      tv[18] = '{1'b1,1'b1,16'hC000,1'b0,4'b1000,32'h2000_0000,1'b1,4'b1000,1'b0,1'b0,32'h0};
      tv[19] = '{1'b1,1'b0,16'h0000,1'b0,4'b0000,32'h2000_0000,1'b0,4'b0000,1'b1,1'b0,32'h2000_0003};

      rst_n = 1'b0;
      bus4.c_req_i = 1'b0; bus4.c_addr_i = '0; bus4.c_wen_i = 1'b0;
      bus4.c_wdata_i = '0; bus4.c_be_i = '0;
      bus4.p_gnt_and_selected_i = '0; bus4.p_rdata_i = '0;
      bus3.c_wdata_i = 32'h1234_5678; bus3.c_be_i = 4'hF;
      for (int k = 0; k < 3; k++) prd[k] = 32'h0;
      drive3(1'b0, 16'h0, 1'b0, 3'b000);
      repeat (2) @(posedge clk);
      #1;

      // Table-driven vectors on the 4-port instance
      for (int i = 0; i < 20; i++) begin
         rst_n                     = tv[i].rst_n;
         bus4.c_req_i              = tv[i].req;
         bus4.c_addr_i             = tv[i].addr;
         bus4.c_wen_i              = tv[i].wen;
         bus4.c_wdata_i            = 32'hDEAD_0000 | 32'(i);
         bus4.c_be_i               = 4'hF;
         bus4.p_gnt_and_selected_i = tv[i].pgnt;
         for (int k = 0; k < 4; k++) bus4.p_rdata_i[32*k +: 32] = tv[i].base | 32'(k);
         #2;
         chk($sformatf("v%0d gnt", i),   32'(bus4.c_gnt_o),          32'(tv[i].e_gnt));
         chk($sformatf("v%0d preq", i),  32'(bus4.port_requested_o), 32'(tv[i].e_preq));
         chk($sformatf("v%0d rv", i),    32'(bus4.c_rvalid_o),       32'(tv[i].e_rv));
         chk($sformatf("v%0d err", i),   32'(bus4.c_err_o),          32'(tv[i].e_err));
         chk($sformatf("v%0d rdata", i), bus4.c_rdata_o,             tv[i].e_rd);
         @(posedge clk);
         #1;
      end
      bus4.c_req_i = 1'b0;
      bus4.p_gnt_and_selected_i = '0;

      // 3-port instance: an illegal decode is granted locally and returns an error
      rst_n = 1'b1;
      prd[0] = 32'hBEEF_0000; prd[1] = 32'hBEEF_0001; prd[2] = 32'hBEEF_0002;
      drive3(1'b1, 16'hC000, 1'b0, 3'b000);
      #2; chk3("ill req", 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      drive3(1'b1, 16'h8000, 1'b0, 3'b100);
      #2; chk3("ill rsp", 1'b1, 3'b100, 1'b1, 1'b1, 32'h0);
      @(posedge clk); #1;
      // The address moves before the response; the data must still come from port 2
      drive3(1'b0, 16'h0000, 1'b0, 3'b001);
      #2; chk3("p2 rsp", 1'b0, 3'b000, 1'b1, 1'b0, 32'hBEEF_0002);
      @(posedge clk); #1;
      drive3(1'b0, 16'h0000, 1'b0, 3'b000);
      #2; chk3("idle", 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;

      // Random traffic on the 3-port instance against a transaction-level model
      for (int c = 0; c < 400; c++) begin
         logic        req, wen, e_gnt, e_rv, e_err, legal;
         logic [15:0] addr;
         logic [2:0]  pgnt, e_preq;
         logic [31:0] e_rd;
         int          sel;
         rst_n = ($urandom_range(0, 19) != 0);
         req   = ($urandom_range(0, 3) != 0);
         addr  = 16'($urandom);
         wen   = 1'($urandom);
         pgnt  = 3'($urandom);
         for (int k = 0; k < 3; k++) prd[k] = $urandom;
         drive3(req, addr, wen, pgnt);
         #2;
         sel    = int'(addr) / 16384;
         legal  = (sel < 3);
         e_preq = 3'b000;
         e_gnt  = 1'b0;
         if (rst_n && req) begin
            if (legal) begin
               e_preq = 3'(1 << sel);
               e_gnt  = pgnt[sel];
            end else begin
               e_gnt = 1'b1;
            end
         end
         e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
         if (pend.size() > 0) begin
            cur = pend.pop_front();
            if (rst_n) begin
               e_rv  = 1'b1;
               e_err = cur.err;
               if (cur.is_rd && !cur.err) e_rd = prd[cur.port];
            end
         end
         chk3($sformatf("rnd%0d", c), e_gnt, e_preq, e_rv, e_err, e_rd);
         if (e_gnt) pend.push_back('{!wen, sel, !legal});
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
